// File: rtl/coin_input_conditioner_pkg.sv
// Shared types and constants for the coin input conditioner.
// Arbiter state encoding and coin channel count.
package coin_input_conditioner_pkg;

  localparam int NUM_COINS = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  function automatic logic multi_hot(
    input logic [NUM_COINS-1:0] v
  );
    return (v & (v - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/coin_input_conditioner_debounce.sv
// One coin channel: 2-flop sync, debounce counter,
// arm-after-low gate and registered rising-edge event.
module coin_debounce #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic ev
);

  localparam logic [CNT_W-1:0] DEB_LAST =
    CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             warm_q;
  logic             armed_q, armed_d;
  logic             ev_q, ev_d;

  // Debounce, arming and edge detection.
  // warm_q marks sync1 holding a real sample, so a
  // sensor stuck high through reset never arms.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == DEB_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    armed_d = armed_q |
      (warm_q & ~stable_q & ~sync1_q & ~sync2_q);
    ev_d = stable_q & ~prev_q & armed_q;
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      warm_q   <= 1'b0;
      armed_q  <= 1'b0;
      ev_q     <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
      warm_q   <= 1'b1;
      armed_q  <= armed_d;
      ev_q     <= ev_d;
    end
  end

  assign ev = ev_q;

endmodule

// File: rtl/coin_input_conditioner.sv
// Coin input conditioner top: three debounced channels
// feeding a single-pulse arbiter with post-event lockout.
module coin_input_conditioner
  import coin_input_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 5,
  parameter int GAP_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic S1,
  input  logic S2,
  input  logic S3,
  output logic B1,
  output logic B2,
  output logic B3,
  output logic REJ,
  output logic BUSY
);

  localparam int GW =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'(GAP_CYCLES - 1);

  logic [NUM_COINS-1:0] raw;
  logic [NUM_COINS-1:0] ev;

  assign raw = {S3, S2, S1};

  for (genvar i = 0; i < NUM_COINS; i++) begin : g_ch
    coin_debounce #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_deb (
      .clk  (clk),
      .rst_n(reset),
      .raw  (raw[i]),
      .ev   (ev[i])
    );
  end

  arb_state_e           state_q, state_d;
  logic [GW-1:0]        gcnt_q, gcnt_d;
  logic [NUM_COINS-1:0] b_q, b_d;
  logic                 rej_q, rej_d;

  // Arbiter next state: one pulse per accepted coin,
  // reject on collisions or events during lockout.
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    b_d     = '0;
    rej_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (multi_hot(ev)) begin
          rej_d   = 1'b1;
          gcnt_d  = '0;
          state_d = ST_GAP;
        end else if (|ev) begin
          b_d     = ev;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        rej_d   = |ev;
        gcnt_d  = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        rej_d = |ev;
        if (gcnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gcnt_q  <= '0;
      b_q     <= '0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      b_q     <= b_d;
      rej_q   <= rej_d;
    end
  end

  assign B1   = b_q[0];
  assign B2   = b_q[1];
  assign B3   = b_q[2];
  assign REJ  = rej_q;
  assign BUSY = (state_q != ST_IDLE);

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner.
// Pulse positions counted in edges from first high sample.
module tb_coin_input_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic S1 = 1'b0, S2 = 1'b0, S3 = 1'b0;
  logic B1, B2, B3, REJ, BUSY;

  int n_chk = 0;
  int n_fail = 0;

  coin_input_conditioner #(
    .DEB_CYCLES(16),
    .CNT_W     (5),
    .GAP_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .S1   (S1),
    .S2   (S2),
    .S3   (S3),
    .B1   (B1),
    .B2   (B2),
    .B3   (B3),
    .REJ  (REJ),
    .BUSY (BUSY)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n cycles, recording pulse counts, first-pulse
  // tick index (1 = first edge) and exclusivity breaks.
  task automatic observe(
    input  int n,
    output int c1, output int c2, output int c3,
    output int cr, output int cbz,
    output int fb, output int fr, output int bad
  );
    logic [2:0] pb;
    c1 = 0; c2 = 0; c3 = 0; cr = 0; cbz = 0;
    fb = -1; fr = -1; bad = 0; pb = '0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (B1) c1++;
      if (B2) c2++;
      if (B3) c3++;
      if (REJ) cr++;
      if (BUSY) cbz++;
      if ((B1 | B2 | B3) && fb < 0) fb = i;
      if (REJ && fr < 0) fr = i;
      if ($countones({B1, B2, B3}) > 1 ||
          ((|pb) && (B1 | B2 | B3))) bad++;
      pb = {B3, B2, B1};
    end
  endtask

  task automatic quiet();
    S1 = 1'b0; S2 = 1'b0; S3 = 1'b0;
    repeat (40) tick();
  endtask

  task automatic test_reset();
    int c1, c2, c3, cr, cbz, fb, fr, bad;
    reset = 1'b0;
    repeat (3) tick();
    n_chk++;
    if ({B1, B2, B3, REJ, BUSY} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outs: got %b want 00000",
               {B1, B2, B3, REJ, BUSY});
    end
    reset = 1'b1;
    observe(20, c1, c2, c3, cr, cbz, fb, fr, bad);
    n_chk++;
    if (c1 + c2 + c3 + cr + cbz !== 0) begin
      n_fail++;
      $display("FAIL reset_idle: got %0d active want 0",
               c1 + c2 + c3 + cr + cbz);
    end
  endtask

  task automatic test_clean();
    int c1, c2, c3, cr, cbz, fb, fr, bad;
    S1 = 1'b1;
    observe(30, c1, c2, c3, cr, cbz, fb, fr, bad);
    n_chk++;
    if (c1 !== 1) begin
      n_fail++;
      $display("FAIL clean_b1_count: got %0d want 1", c1);
    end
    n_chk++;
    if (fb !== 20) begin
      n_fail++;
      $display("FAIL clean_b1_time: got %0d want 20", fb);
    end
    n_chk++;
    if (cr !== 0 || c2 + c3 !== 0) begin
      n_fail++;
      $display("FAIL clean_other: got rej %0d b23 %0d want 0",
               cr, c2 + c3);
    end
    n_chk++;
    if (cbz !== 5) begin
      n_fail++;
      $display("FAIL clean_busy: got %0d want 5", cbz);
    end
    quiet();
  endtask

  task automatic test_bounce();
    int c1, c2, c3, cr, cbz, fb, fr, bad;
    int acc;
    acc = 0;
    for (int t = 0; t < 10; t++) begin
      S2 = ~S2;
      observe(3, c1, c2, c3, cr, cbz, fb, fr, bad);
      acc += c1 + c2 + c3 + cr;
    end
    n_chk++;
    if (acc !== 0) begin
      n_fail++;
      $display("FAIL bounce_quiet: got %0d want 0", acc);
    end
    S2 = 1'b1;
    observe(30, c1, c2, c3, cr, cbz, fb, fr, bad);
    n_chk++;
    if (c2 !== 1 || fb !== 20) begin
      n_fail++;
      $display("FAIL bounce_b2: got cnt %0d at %0d want 1 at 20",
               c2, fb);
    end
    quiet();
  endtask

  task automatic test_collision();
    int c1, c2, c3, cr, cbz, fb, fr, bad;
    S1 = 1'b1;
    S3 = 1'b1;
    observe(30, c1, c2, c3, cr, cbz, fb, fr, bad);
    n_chk++;
    if (cr !== 1 || fr !== 20) begin
      n_fail++;
      $display("FAIL coll_rej: got cnt %0d at %0d want 1 at 20",
               cr, fr);
    end
    n_chk++;
    if (c1 + c2 + c3 !== 0) begin
      n_fail++;
      $display("FAIL coll_nob: got %0d want 0", c1 + c2 + c3);
    end
    n_chk++;
    if (cbz !== 4) begin
      n_fail++;
      $display("FAIL coll_busy: got %0d want 4", cbz);
    end
    quiet();
  endtask

  task automatic test_lockout();
    int c1, c2, c3, cr, cbz, fb, fr, bad;
    S1 = 1'b1;
    observe(3, c1, c2, c3, cr, cbz, fb, fr, bad);
    S2 = 1'b1;
    observe(30, c1, c2, c3, cr, cbz, fb, fr, bad);
    n_chk++;
    if (c1 !== 1 || fb !== 17) begin
      n_fail++;
      $display("FAIL lock_b1: got cnt %0d at %0d want 1 at 17",
               c1, fb);
    end
    n_chk++;
    if (c2 !== 0) begin
      n_fail++;
      $display("FAIL lock_nob2: got %0d want 0", c2);
    end
    n_chk++;
    if (cr !== 1 || fr !== 20) begin
      n_fail++;
      $display("FAIL lock_rej: got cnt %0d at %0d want 1 at 20",
               cr, fr);
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL lock_excl: got %0d want 0", bad);
    end
    quiet();
  endtask

  task automatic test_stuck();
    int c1, c2, c3, cr, cbz, fb, fr, bad;
    S3 = 1'b1;
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    observe(40, c1, c2, c3, cr, cbz, fb, fr, bad);
    n_chk++;
    if (c3 !== 0 || cr !== 0) begin
      n_fail++;
      $display("FAIL stuck_nob3: got b3 %0d rej %0d want 0",
               c3, cr);
    end
    S3 = 1'b0;
    observe(20, c1, c2, c3, cr, cbz, fb, fr, bad);
    n_chk++;
    if (c3 !== 0) begin
      n_fail++;
      $display("FAIL stuck_fall: got %0d want 0", c3);
    end
    S3 = 1'b1;
    observe(30, c1, c2, c3, cr, cbz, fb, fr, bad);
    n_chk++;
    if (c3 !== 1 || fb !== 20) begin
      n_fail++;
      $display("FAIL stuck_b3: got cnt %0d at %0d want 1 at 20",
               c3, fb);
    end
    quiet();
  endtask

  task automatic test_reset_midop();
    int c1, c2, c3, cr, cbz, fb, fr, bad;
    S2 = 1'b1;
    observe(19, c1, c2, c3, cr, cbz, fb, fr, bad);
    tick();
    n_chk++;
    if (B2 !== 1'b1 || c2 !== 0) begin
      n_fail++;
      $display("FAIL mid_b2_pre: got %b early %0d want 1 0",
               B2, c2);
    end
    reset = 1'b0;
    #1;
    n_chk++;
    if ({B1, B2, B3, REJ, BUSY} !== 5'b0) begin
      n_fail++;
      $display("FAIL mid_drop: got %b want 00000",
               {B1, B2, B3, REJ, BUSY});
    end
    tick();
    reset = 1'b1;
    observe(40, c1, c2, c3, cr, cbz, fb, fr, bad);
    n_chk++;
    if (c2 !== 0 || cr !== 0) begin
      n_fail++;
      $display("FAIL mid_nob2: got b2 %0d rej %0d want 0",
               c2, cr);
    end
    S2 = 1'b0;
    observe(20, c1, c2, c3, cr, cbz, fb, fr, bad);
    S2 = 1'b1;
    observe(30, c1, c2, c3, cr, cbz, fb, fr, bad);
    n_chk++;
    if (c2 !== 1 || fb !== 20) begin
      n_fail++;
      $display("FAIL mid_b2_new: got cnt %0d at %0d want 1 at 20",
               c2, fb);
    end
    quiet();
  endtask

  initial begin
    test_reset();
    test_clean();
    test_bounce();
    test_collision();
    test_lockout();
    test_stuck();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
